async_responder_fifo: RTL and testbench
=======================================

// Module: async_responder_fifo
// PURPOSE
//   Responder (serving) end of the pull req/ack handshake used between dataflow operators.
//   - Push side: buffers words written by a local pipeline.
//   - Pull side: answers OUTPUT_SIZE requesters, each with its own req/ack pair.
//   - Broadcast: every requester receives every word exactly once, in write order.
//   Sits where a graph input or fan-out node must serve downstream operators independently.
// PARAMETERS
//   data_width   32  word width
//   depth        4   FIFO entries; power of two, >=2
//   output_size  1   number of independent requesters, >=1
// PORTS
//   clk       in   1                        single clock, all logic on posedge
//   rst       in   1                        synchronous, active-high reset
//   wr_en     in   1                        push request; ignored while full=1
//   wr_data   in   data_width               word to push
//   full      out  1                        1 = some requester still holds depth unread words
//   empty     out  1                        1 = no requester has an unread word
//   req       in   output_size              per-requester pull request (level)
//   ack       out  output_size              per-requester acknowledge, one-cycle pulse
//   dout      out  data_width*output_size   per-requester data; slice i = bits [i*dw +: dw]
// BEHAVIOUR
//   - Reset: ack=0, dout=0, empty=1, full=0. All pointers are cleared and buffered words discarded.
//     Reset mid-operation behaves the same: an ack pulse in flight is dropped the next cycle.
//   - Pointers:
//     - wr_ptr and rd_ptr[i] are each clog2(depth)+1 bits and wrap naturally.
//     - occ[i] = wr_ptr - rd_ptr[i].
//     - full = (max occ[i] == depth); empty = (max occ[i] == 0).
//   - Push: wr_en & ~full writes mem[wr_ptr], then wr_ptr+1. wr_en while full is dropped, no error.
//   - Serve port i:
//     - When req[i] & ~ack[i] & occ[i]!=0, at the edge: ack[i]<=1, dout slice i <= mem[rd_ptr[i]], rd_ptr[i]+1.
//     - Otherwise ack[i]<=0, and dout slice i holds its last value.
//     - ack never stays high two consecutive cycles, so the maximum rate is 1 word / 2 cycles per port.
//   - Data timing: dout is stable in the same cycle ack is high and does not change until the next ack.
//     Requesters may therefore latch on posedge ack.
//   - Latency: a word pushed at edge t can first be acked at edge t+1. There is no write-through.
//   - Simultaneous push and serve in one cycle are both legal:
//     - full/empty are computed from the post-edge pointers;
//     - push while full is still refused even if a serve frees a slot in the same cycle.
//   - A slot is retired only after all output_size ports have read it; the slowest port throttles the push side.
//   - req deasserted while data is pending leaves the word queued. A requester is never skipped.
//   - Ports are independent: no ordering is enforced between ports, and a stalled port never blocks another port's ack.
// CONFIGURATION
//   ASYNC_RESP_STATS_EN
//     - Defined: adds output count [32*output_size] with per-port acks since reset (wraps at 2^32),
//       plus output overflow_drops [32] counting wr_en asserted while full. Both are 0 after reset.
//     - Undefined: neither port exists and no counter logic is built.
//       Handshake timing is identical in both builds.
// STRUCTURE
//   - Shared package async_hs_pkg:
//     - ptr-width helper: clog2(depth)+1;
//     - handshake constants: ACK_PULSE=1, MIN_ACK_GAP=1;
//     - default data_width.
//   - Sub-module async_resp_port (one per requester, generated):
//     - holds rd_ptr[i], the ack[i] pulse register and the dout slice register;
//     - reads mem through a combinational read port.
//   - Top level holds mem, wr_ptr, the max-occupancy reduction and full/empty.
// TESTING
//   1. Reset with all req=0: ack=0, dout=0, empty=1, full=0. After reset, req[0]=1 with no pushes -> ack stays 0 for 20 cycles.
//   2. output_size=1, depth=4: push 1,2,3,4 back-to-back -> full=1 after the 4th.
//      Push 5 while full -> dropped. req=1 continuously -> acks in every other cycle carrying 1,2,3,4.
//      empty=1 after the last ack.
//   3. Push 0xA at edge t with req high -> first ack at edge t+1 with dout=0xA, not earlier.
//   4. output_size=2: port1 req held 0, push 1..4 -> port0 receives 1..4 and full stays 1.
//      Then port1 req=1 -> port1 receives 1..4, full drops after its first ack.
//   5. Assert rst mid-stream with 3 words queued and an ack high -> next cycle ack=0, dout=0, empty=1.
//      After push 7 -> first ack returns 7.
//   6. With ASYNC_RESP_STATS_EN: scenario 2 -> count[0]=4, overflow_drops=1.
//      Without the macro, the bench builds without these ports.

Source files
------------

// File: rtl/async_hs_pkg.sv
//==============================================================================
// Module      : async_hs_pkg
// Description : Shared constants and pointer-width helper for the pull
//               req/ack handshake used by async_responder_fifo.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

package async_hs_pkg;

    localparam int DEFAULT_DATA_WIDTH = 32;

    // ack is a single-cycle pulse followed by at least one idle cycle
    localparam int ACK_PULSE   = 1;
    localparam int MIN_ACK_GAP = 1;

    // One extra bit beyond the address lets full and empty be told apart
    function automatic int ptr_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/async_resp_port.sv
//==============================================================================
// Module      : async_resp_port
// Description : One requester port: read pointer, ack pulse and held data.
//               Optional ack counter when ASYNC_RESP_STATS_EN is defined.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module async_resp_port
    import async_hs_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int PTR_W      = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req,
    input  logic [PTR_W-1:0]      wr_ptr,
    input  logic [DATA_WIDTH-1:0] rd_data,
    output logic [PTR_W-2:0]      rd_addr,
    output logic [PTR_W-1:0]      occ,
    output logic                  ack,
    output logic [DATA_WIDTH-1:0] dout
`ifdef ASYNC_RESP_STATS_EN
    ,
    output logic [31:0]           count
`endif
);

    logic [PTR_W-1:0]      r_rd_ptr;
    logic                  r_ack;
    logic [DATA_WIDTH-1:0] r_dout;
    logic                  w_serve;

    assign occ     = wr_ptr - r_rd_ptr;
    assign rd_addr = r_rd_ptr[PTR_W-2:0];

    // Blocking on r_ack enforces the idle cycle between consecutive acks
    assign w_serve = req & ~r_ack & (occ != '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ack    <= 1'b0;
            r_dout   <= '0;
            r_rd_ptr <= '0;
        end else begin
            r_ack <= w_serve;
            if (w_serve) begin
                r_dout   <= rd_data;
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
        end
    end

    assign ack  = r_ack;
    assign dout = r_dout;

`ifdef ASYNC_RESP_STATS_EN
    logic [31:0] r_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (w_serve) begin
            r_count <= r_count + 32'd1;
        end
    end

    assign count = r_count;
`endif

endmodule

`default_nettype wire

// File: rtl/async_responder_fifo.sv
//==============================================================================
// Module      : async_responder_fifo
// Description : Broadcast FIFO serving OUTPUT_SIZE pull requesters; every
//               requester sees every word once, in write order. Defining
//               ASYNC_RESP_STATS_EN adds ack counters and an overflow counter.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module async_responder_fifo
    import async_hs_pkg::*;
#(
    parameter int DATA_WIDTH  = DEFAULT_DATA_WIDTH,
    parameter int DEPTH       = 4,
    parameter int OUTPUT_SIZE = 1
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             wr_en,
    input  logic [DATA_WIDTH-1:0]            wr_data,
    output logic                             full,
    output logic                             empty,
    input  logic [OUTPUT_SIZE-1:0]           req,
    output logic [OUTPUT_SIZE-1:0]           ack,
    output logic [DATA_WIDTH*OUTPUT_SIZE-1:0] dout
`ifdef ASYNC_RESP_STATS_EN
    ,
    output logic [32*OUTPUT_SIZE-1:0]        count,
    output logic [31:0]                      overflow_drops
`endif
);

    localparam int PTR_W  = ptr_width(DEPTH);
    localparam int ADDR_W = PTR_W - 1;

    generate
        if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0) || (OUTPUT_SIZE < 1) ||
            (ACK_PULSE != 1) || (MIN_ACK_GAP != 1)) begin : g_cfg_check
            $error("async_responder_fifo: unsupported configuration");
        end
    endgenerate

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]      r_wr_ptr;
    logic [ADDR_W-1:0]     w_rd_addr [OUTPUT_SIZE];
    logic [PTR_W-1:0]      w_occ     [OUTPUT_SIZE];
    logic [PTR_W-1:0]      w_max_occ;
    logic                  w_push;

    // full reflects current pointers, so a same-cycle serve cannot admit a push
    assign w_push = wr_en & ~full;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
        end else if (w_push) begin
            r_wr_ptr <= r_wr_ptr + PTR_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr[ADDR_W-1:0]] <= wr_data;
        end
    end

    generate
        for (genvar i = 0; i < OUTPUT_SIZE; i++) begin : g_port
            async_resp_port #(
                .DATA_WIDTH (DATA_WIDTH),
                .PTR_W      (PTR_W)
            ) u_port (
                .clk     (clk),
                .rst     (rst),
                .req     (req[i]),
                .wr_ptr  (r_wr_ptr),
                .rd_data (r_mem[w_rd_addr[i]]),
                .rd_addr (w_rd_addr[i]),
                .occ     (w_occ[i]),
                .ack     (ack[i]),
                .dout    (dout[i*DATA_WIDTH +: DATA_WIDTH])
`ifdef ASYNC_RESP_STATS_EN
                ,
                .count   (count[i*32 +: 32])
`endif
            );
        end
    endgenerate

    // The slowest requester decides whether a slot can be reused
    always_comb begin
        w_max_occ = '0;
        for (int i = 0; i < OUTPUT_SIZE; i++) begin
            if (w_occ[i] > w_max_occ) begin
                w_max_occ = w_occ[i];
            end
        end
    end

    assign full  = (w_max_occ == PTR_W'(DEPTH));
    assign empty = (w_max_occ == '0);

`ifdef ASYNC_RESP_STATS_EN
    logic [31:0] r_overflow_drops;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_overflow_drops <= '0;
        end else if (wr_en & full) begin
            r_overflow_drops <= r_overflow_drops + 32'd1;
        end
    end

    assign overflow_drops = r_overflow_drops;
`endif

endmodule

`default_nettype wire

// File: tb/tb_async_responder_fifo.sv
//==============================================================================
// Module      : tb_async_responder_fifo
// Description : Scoreboard bench for async_responder_fifo with one- and
//               two-requester instances; ASYNC_RESP_STATS_EN adds counter checks.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_async_responder_fifo;

    localparam int DW    = 32;
    localparam int DEPTH = 4;

    logic        clk     = 1'b0;
    logic        rst     = 1'b1;
    logic        wr_en   = 1'b0;
    logic [31:0] wr_data = '0;
    logic        req_a   = 1'b0;
    logic [1:0]  req_b   = '0;
    bit          mon_en  = 1'b0;

    logic        full_a, empty_a, ack_a;
    logic [31:0] dout_a;
    logic        full_b, empty_b;
    logic [1:0]  ack_b;
    logic [63:0] dout_b;
`ifdef ASYNC_RESP_STATS_EN
    logic [31:0] count_a, drops_a, drops_b;
    logic [63:0] count_b;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    async_responder_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .OUTPUT_SIZE(1)) dut_a (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data),
        .full(full_a), .empty(empty_a), .req(req_a), .ack(ack_a), .dout(dout_a)
`ifdef ASYNC_RESP_STATS_EN
        , .count(count_a), .overflow_drops(drops_a)
`endif
    );

    async_responder_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .OUTPUT_SIZE(2)) dut_b (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data),
        .full(full_b), .empty(empty_b), .req(req_b), .ack(ack_b), .dout(dout_b)
`ifdef ASYNC_RESP_STATS_EN
        , .count(count_b), .overflow_drops(drops_b)
`endif
    );

    task automatic check(input bit ok, input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        n_checks++;
        if (ok) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Reference model: per instance, the list of accepted words plus how far
    // each requester has read into it (index 0 = one port, index 1 = two ports)
    logic [31:0] hist   [2][$];
    logic [31:0] exp_q  [4][$];
    int unsigned m_wcnt [2];
    int unsigned m_drops[2];
    int unsigned m_rd   [2][2];
    int unsigned m_cnt  [2][2];
    bit          m_ack  [2][2];
    logic [31:0] m_dout [2][2];

    function automatic int unsigned max_unread(input int d);
        int unsigned mx = 0;
        for (int p = 0; p <= d; p++)
            if (m_wcnt[d] - m_rd[d][p] > mx) mx = m_wcnt[d] - m_rd[d][p];
        return mx;
    endfunction

    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            bit         was_full;
            logic [1:0] r;
            if (rst) begin
                hist[d].delete();
                m_wcnt[d]  = 0;
                m_drops[d] = 0;
                for (int p = 0; p < 2; p++) begin
                    m_rd[d][p]   = 0;
                    m_cnt[d][p]  = 0;
                    m_ack[d][p]  = 1'b0;
                    m_dout[d][p] = '0;
                    exp_q[d*2+p].delete();
                end
            end else begin
                was_full = (max_unread(d) == DEPTH);
                r = (d == 0) ? {1'b0, req_a} : req_b;
                for (int p = 0; p <= d; p++) begin
                    if (r[p] && !m_ack[d][p] && m_wcnt[d] != m_rd[d][p]) begin
                        m_dout[d][p] = hist[d][m_rd[d][p]];
                        exp_q[d*2+p].push_back(m_dout[d][p]);
                        m_rd[d][p]++;
                        m_cnt[d][p]++;
                        m_ack[d][p] = 1'b1;
                    end else begin
                        m_ack[d][p] = 1'b0;
                    end
                end
                if (wr_en) begin
                    if (!was_full) begin
                        hist[d].push_back(wr_data);
                        m_wcnt[d]++;
                    end else begin
                        m_drops[d]++;
                    end
                end
            end
        end
    end

    // Monitor: compares flags every cycle and pops the scoreboard on each ack
    always @(negedge clk) begin
        if (mon_en) begin
            for (int d = 0; d < 2; d++) begin
                logic        f, e, a;
                logic [31:0] dv, ev;
                f = (d == 0) ? full_a  : full_b;
                e = (d == 0) ? empty_a : empty_b;
                check(f == (max_unread(d) == DEPTH), $sformatf("full[%0d]", d), f, max_unread(d) == DEPTH);
                check(e == (max_unread(d) == 0), $sformatf("empty[%0d]", d), e, max_unread(d) == 0);
                for (int p = 0; p <= d; p++) begin
                    a  = (d == 0) ? ack_a  : ack_b[p];
                    dv = (d == 0) ? dout_a : dout_b[p*32 +: 32];
                    check(a == m_ack[d][p], $sformatf("ack[%0d.%0d]", d, p), a, m_ack[d][p]);
                    if (a) begin
                        if (exp_q[d*2+p].size() == 0) begin
                            check(1'b0, $sformatf("ack_unexpected[%0d.%0d]", d, p), a, 0);
                        end else begin
                            ev = exp_q[d*2+p].pop_front();
                            check(dv == ev, $sformatf("ack_data[%0d.%0d]", d, p), dv, ev);
                        end
                    end else begin
                        check(dv == m_dout[d][p], $sformatf("dout_hold[%0d.%0d]", d, p), dv, m_dout[d][p]);
                    end
                end
            end
`ifdef ASYNC_RESP_STATS_EN
            check(count_a == m_cnt[0][0], "count_a", count_a, m_cnt[0][0]);
            check(count_b[31:0] == m_cnt[1][0], "count_b0", count_b[31:0], m_cnt[1][0]);
            check(count_b[63:32] == m_cnt[1][1], "count_b1", count_b[63:32], m_cnt[1][1]);
            check(drops_a == m_drops[0], "drops_a", drops_a, m_drops[0]);
            check(drops_b == m_drops[1], "drops_b", drops_b, m_drops[1]);
`endif
        end
    end

    task automatic step(input bit rs, input bit we, input logic [31:0] wd,
                        input bit ra, input logic [1:0] rb);
        @(negedge clk);
        rst = rs; wr_en = we; wr_data = wd; req_a = ra; req_b = rb;
    endtask

    initial begin
        bit found;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        mon_en = 1'b1;
        check(ack_a == 1'b0,  "rst_ack",   ack_a,   0);
        check(dout_a == '0,   "rst_dout",  dout_a,  0);
        check(empty_a == 1'b1,"rst_empty", empty_a, 1);
        check(full_a == 1'b0, "rst_full",  full_a,  0);

        // Requests with nothing pushed must never be acked
        repeat (20) step(0, 0, 0, 1, 2'b11);
        check(ack_a == 1'b0 && ack_b == 2'b00, "s1_no_ack", {ack_b, ack_a}, 0);

        // Fill to full, overflow once, then drain
        step(0, 0, 0, 0, 2'b00);
        for (int v = 1; v <= 4; v++) step(0, 1, v, 0, 2'b00);
        step(0, 1, 5, 0, 2'b00);
        check(full_a == 1'b1, "s2_full_a", full_a, 1);
        check(full_b == 1'b1, "s2_full_b", full_b, 1);
        repeat (10) step(0, 0, 0, 1, 2'b01);
        check(empty_a == 1'b1, "s2_empty_a", empty_a, 1);
        check(full_b == 1'b1, "s4_full_held", full_b, 1);
`ifdef ASYNC_RESP_STATS_EN
        check(count_a == 32'd4, "s6_count", count_a, 4);
        check(drops_a == 32'd1, "s6_drops", drops_a, 1);
`endif
        repeat (12) step(0, 0, 0, 1, 2'b11);
        check(empty_b == 1'b1, "s4_empty_b", empty_b, 1);

        // No write-through: ack comes one edge after the push
        step(0, 1, 32'hA, 1, 2'b11);
        step(0, 0, 0, 1, 2'b11);
        check(ack_a == 1'b0, "s3_not_early", ack_a, 0);
        step(0, 0, 0, 1, 2'b11);
        check(ack_a == 1'b1 && dout_a == 32'hA, "s3_first_ack", {ack_a, dout_a}, {1'b1, 32'hA});
        repeat (3) step(0, 0, 0, 0, 2'b00);

        // Reset while an ack is in flight with words still queued
        for (int k = 1; k <= 4; k++) step(0, 1, 32'h10 + k, 0, 2'b00);
        found = 1'b0;
        for (int k = 0; k < 20 && !found; k++) begin
            step(0, 0, 0, 1, 2'b11);
            if (ack_a) found = 1'b1;
        end
        check(found, "s5_ack_seen", found, 1);
        rst = 1'b1;
        step(0, 0, 0, 0, 2'b00);
        check(ack_a == 1'b0,   "s5_ack",   ack_a,   0);
        check(dout_a == '0,    "s5_dout",  dout_a,  0);
        check(empty_a == 1'b1, "s5_empty", empty_a, 1);
        step(0, 1, 7, 1, 2'b11);
        step(0, 0, 0, 1, 2'b11);
        step(0, 0, 0, 1, 2'b11);
        check(ack_a == 1'b1 && dout_a == 32'd7, "s5_after_rst", {ack_a, dout_a}, {1'b1, 32'd7});

        // Random traffic, occasional reset
        repeat (3000) begin
            step($urandom_range(0, 299) == 0, 1'($urandom_range(0, 1)), $urandom,
                 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)));
        end
        repeat (4) step(0, 0, 0, 0, 2'b00);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
